// File: rtl/regdump_pkg.sv
// Shared constants and FSM state encoding for the register-file dump reader.
package regdump_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_PRESENT,
    ST_CSUM,
    ST_FIN
  } state_t;
endpackage

// File: rtl/regfile_dump_reader.sv
// Streams (addr,data) for a register window: first valid 2 cycles after start, one beat per 2 cycles max, beat held under !out_ready.
// Optional REGDUMP_CHECKSUM_EN appends an XOR-of-data beat at addr 0 before done.
module regfile_dump_reader
  import regdump_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   first_addr,
  input  logic [AW-1:0]   last_addr,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic            rf_we,
  input  logic [AW-1:0]   rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_addr,
  output logic [XLEN-1:0] out_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

`ifdef REGDUMP_CHECKSUM_EN
  localparam state_t AFTER_LAST = ST_CSUM;
`else
  localparam state_t AFTER_LAST = ST_FIN;
`endif

  state_t          r_state, w_next;
  logic [AW-1:0]   r_ptr, r_end, r_raddr, r_out_addr;
  logic [XLEN-1:0] r_out_data, w_rd_data;
  logic            r_out_valid, r_busy, r_err, r_bad_done;
  logic            w_hs, w_last, w_good_start, w_bad_start;
`ifdef REGDUMP_CHECKSUM_EN
  logic [XLEN-1:0] r_csum;
`endif

  assign w_hs         = r_out_valid && out_ready;
  assign w_last       = (r_ptr == r_end);
  assign w_good_start = (r_state == ST_IDLE) && start && (first_addr <= last_addr);
  assign w_bad_start  = (r_state == ST_IDLE) && start && (first_addr > last_addr);
  // A write landing on the address being read this cycle wins over the stale array value.
  assign w_rd_data    = (rf_we && (rf_waddr == r_ptr) && (r_ptr != '0)) ? rf_wdata : rf_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_good_start) w_next = ST_READ;
      ST_READ:    w_next = ST_PRESENT;
      ST_PRESENT: if (w_hs) w_next = w_last ? AFTER_LAST : ST_READ;
`ifdef REGDUMP_CHECKSUM_EN
      ST_CSUM:    if (w_hs) w_next = ST_FIN;
`endif
      ST_FIN:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_end       <= '0;
      r_raddr     <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_bad_done  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_bad_done <= w_bad_start;
      case (r_state)
        ST_IDLE: begin
          if (w_bad_start) r_err <= 1'b1;
          if (w_good_start) begin
            r_ptr   <= first_addr;
            r_end   <= last_addr;
            r_raddr <= first_addr;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        ST_READ: begin
          r_out_data  <= w_rd_data;
          r_out_addr  <= r_ptr;
          r_out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          r_csum      <= r_csum ^ w_rd_data;
`endif
        end
        ST_PRESENT: begin
          if (w_hs) begin
            if (w_last) begin
`ifdef REGDUMP_CHECKSUM_EN
              // Checksum beat follows back-to-back; accumulator already holds the last beat.
              r_out_addr  <= '0;
              r_out_data  <= r_csum;
`else
              r_out_valid <= 1'b0;
`endif
            end else begin
              r_out_valid <= 1'b0;
              r_ptr       <= r_ptr + 1'b1;
              r_raddr     <= r_ptr + 1'b1;
            end
          end
        end
        ST_CSUM: if (w_hs) r_out_valid <= 1'b0;
        ST_FIN:  r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rf_raddr  = r_raddr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign err       = r_err;
  assign done      = (r_state == ST_FIN) || r_bad_done;

endmodule
